// File: rtl/entrada_credencial_pkg.sv
// Shared types and constants for the serial credential front-end.
// States, credential width and grant-level encoding.
package entrada_credencial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        RESULT,
        LOCKOUT
    } estado_t;

    localparam int CRED_W = 6;

    localparam logic [1:0] NIVEL_NENHUM = 2'd0;
    localparam logic [1:0] NIVEL_1      = 2'd1;
    localparam logic [1:0] NIVEL_2      = 2'd2;
    localparam logic [1:0] NIVEL_3      = 2'd3;

    // Highest set AUT bit wins.
    function automatic logic [1:0] nivel_de(input logic [2:0] aut);
        logic [1:0] n;
        n = NIVEL_NENHUM;
        if (aut[2])
            n = NIVEL_3;
        else if (aut[1])
            n = NIVEL_2;
        else if (aut[0])
            n = NIVEL_1;
        return n;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/contador_intervalo.sv
// Loadable down-counter with a zero flag.
// One instance times result hold, lockout and entry timeout.
module contador_intervalo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] valor,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= valor;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/entrada_credencial_serial.sv
// Serial credential entry, comparator handshake, result hold and lockout.
// Optional entry inactivity timeout: define ENTRADA_TIMEOUT_EN.
module entrada_credencial_serial
    import entrada_credencial_pkg::*;
#(
    parameter int LOCK_TRIES     = 3,
    parameter int LOCK_CYCLES    = 1000,
    parameter int RESULT_CYCLES  = 50,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              confirm,
    input  logic              clear,
    input  logic [2:0]        aut_in,
    output logic [CRED_W-1:0] cred,
    output logic              cred_valid,
    output logic              granted,
    output logic              denied,
    output logic [1:0]        level,
    output logic              locked,
    output logic              busy
);

    localparam int CNT_MAX =
        max3(LOCK_CYCLES, RESULT_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    estado_t           state_q, state_d;
    logic [CRED_W-1:0] cred_d;
    logic [2:0]        count_q, count_d;
    logic [2:0]        fail_q, fail_d;
    logic [1:0]        level_d;
    logic              granted_d, denied_d;
    logic              tmr_load, tmr_done;
    logic [CNT_W-1:0]  tmr_valor;

    contador_intervalo #(.W(CNT_W)) u_tmr (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .valor (tmr_valor),
        .done  (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        cred_d    = cred;
        count_d   = count_q;
        fail_d    = fail_q;
        level_d   = level;
        granted_d = granted;
        denied_d  = denied;
        tmr_load  = 1'b0;
        tmr_valor = '0;
        unique case (state_q)
            IDLE: begin
                if (bit_valid) begin
                    cred_d  = {{(CRED_W-1){1'b0}}, bit_in};
                    count_d = 3'd1;
                    state_d = ENTRY;
`ifdef ENTRADA_TIMEOUT_EN
                    tmr_load  = 1'b1;
                    tmr_valor = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                end
            end
            ENTRY: begin
                if (clear) begin
                    cred_d  = '0;
                    count_d = '0;
                    state_d = IDLE;
                end else if (confirm) begin
                    state_d = CHECK;
                end else if (bit_valid) begin
                    if (count_q < 3'(CRED_W)) begin
                        cred_d  = {cred[CRED_W-2:0], bit_in};
                        count_d = count_q + 3'd1;
                    end
`ifdef ENTRADA_TIMEOUT_EN
                    tmr_load  = 1'b1;
                    tmr_valor = CNT_W'(TIMEOUT_CYCLES - 1);
                end else if (tmr_done) begin
                    cred_d  = '0;
                    count_d = '0;
                    state_d = IDLE;
`endif
                end
            end
            CHECK: begin
                state_d   = RESULT;
                tmr_load  = 1'b1;
                tmr_valor = CNT_W'(RESULT_CYCLES - 1);
                // Short entries are denied no matter what the comparator says.
                if (count_q == 3'(CRED_W) && aut_in != 3'b000) begin
                    granted_d = 1'b1;
                    level_d   = nivel_de(aut_in);
                    fail_d    = '0;
                end else begin
                    denied_d = 1'b1;
                    level_d  = NIVEL_NENHUM;
                    fail_d   = fail_q + 3'd1;
                end
            end
            RESULT: begin
                if (tmr_done) begin
                    granted_d = 1'b0;
                    denied_d  = 1'b0;
                    level_d   = NIVEL_NENHUM;
                    cred_d    = '0;
                    count_d   = '0;
                    if (denied && fail_q == 3'(LOCK_TRIES)) begin
                        state_d   = LOCKOUT;
                        tmr_load  = 1'b1;
                        tmr_valor = CNT_W'(LOCK_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKOUT: begin
                if (tmr_done) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cred       <= '0;
            count_q    <= '0;
            fail_q     <= '0;
            level      <= NIVEL_NENHUM;
            granted    <= 1'b0;
            denied     <= 1'b0;
            cred_valid <= 1'b0;
            locked     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cred       <= cred_d;
            count_q    <= count_d;
            fail_q     <= fail_d;
            level      <= level_d;
            granted    <= granted_d;
            denied     <= denied_d;
            cred_valid <= (state_d == CHECK);
            locked     <= (state_d == LOCKOUT);
            busy       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_entrada_credencial_serial.sv
// Directed bench for entrada_credencial_serial with default parameters.
// Build with ENTRADA_TIMEOUT_EN to also cover the entry timeout.
module tb_entrada_credencial_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       confirm = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] aut_in = 3'b000;
    logic [5:0] cred;
    logic       cred_valid;
    logic       granted;
    logic       denied;
    logic [1:0] level;
    logic       locked;
    logic       busy;

    int nvec = 0;
    int nerr = 0;

    entrada_credencial_serial dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .confirm    (confirm),
        .clear      (clear),
        .aut_in     (aut_in),
        .cred       (cred),
        .cred_valid (cred_valid),
        .granted    (granted),
        .denied     (denied),
        .level      (level),
        .locked     (locked),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Sends the low n bits of v, first bit = v[n-1].
    task automatic entrar(input int n, input logic [5:0] v);
        for (int i = n - 1; i >= 0; i--)
            pulse_bit(v[i]);
    endtask

    task automatic avaliar(input string tag, input logic [2:0] aut,
                           input logic [5:0] exp_cred,
                           input logic exp_g, input logic [1:0] exp_lvl);
        int n;
        aut_in  = aut;
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        chk({tag, "_cred_valid"}, cred_valid, 1);
        chk({tag, "_cred"}, cred, exp_cred);
        tick();
        aut_in = 3'b000;
        chk({tag, "_granted"}, granted, exp_g);
        chk({tag, "_denied"}, denied, !exp_g);
        chk({tag, "_level"}, level, exp_lvl);
        n = 0;
        while ((granted || denied) && n < 200) begin
            n++;
            tick();
        end
        chk({tag, "_hold"}, n, 50);
        chk({tag, "_lvl_clr"}, level, 0);
        chk({tag, "_cred_clr"}, cred, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick();
        tick();
        chk("rst_outs",
            {cred, cred_valid, granted, denied, level, locked, busy}, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        chk("idle_confirm", busy, 0);

        pulse_bit(1'b0);
        chk("entry_busy", busy, 1);
        chk("first_bit", cred, 6'b000000);
        entrar(5, 6'b11000);
        chk("t1_cred", cred, 6'b011000);
        avaliar("t1", 3'b001, 6'b011000, 1'b1, 2'd1);
        chk("t1_idle", busy, 0);

        entrar(4, 6'b001011);
        avaliar("short", 3'b111, 6'b001011, 1'b0, 2'd0);
        entrar(4, 6'b000101);
        avaliar("short2", 3'b111, 6'b000101, 1'b0, 2'd0);
        entrar(6, 6'b101010);
        avaliar("lvl3", 3'b110, 6'b101010, 1'b1, 2'd3);
        entrar(6, 6'b000000);
        avaliar("deny0", 3'b000, 6'b000000, 1'b0, 2'd0);
        chk("fail_cleared", locked, 0);
        chk("fail_cleared_idle", busy, 0);

        entrar(6, 6'b110011);
        pulse_bit(1'b0);
        chk("seventh_ignored", cred, 6'b110011);
        avaliar("lvl2", 3'b011, 6'b110011, 1'b1, 2'd2);

        entrar(2, 6'b000011);
        clear   = 1'b1;
        confirm = 1'b1;
        tick();
        clear   = 1'b0;
        confirm = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_cred", cred, 0);
        tick();
        chk("clr_no_check", cred_valid, 0);

        entrar(6, 6'b111111);
        avaliar("lk1", 3'b000, 6'b111111, 1'b0, 2'd0);
        entrar(3, 6'b000101);
        avaliar("lk2", 3'b001, 6'b000101, 1'b0, 2'd0);
        entrar(6, 6'b010101);
        avaliar("lk3", 3'b000, 6'b010101, 1'b0, 2'd0);
        chk("lock_rise", locked, 1);
        n = 0;
        while (locked && n < 2000) begin
            n++;
            bit_valid = n[0];
            confirm   = n[1];
            bit_in    = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        confirm   = 1'b0;
        bit_in    = 1'b0;
        chk("lock_len", n, 1000);
        chk("lock_idle", busy, 0);
        chk("lock_cred", cred, 0);
        entrar(6, 6'b100001);
        avaliar("post_lock", 3'b100, 6'b100001, 1'b1, 2'd3);

`ifdef ENTRADA_TIMEOUT_EN
        entrar(6, 6'b000001);
        avaliar("to_d1", 3'b000, 6'b000001, 1'b0, 2'd0);
        entrar(3, 6'b000111);
        n = 0;
        while (busy && n < 6000) begin
            n++;
            tick();
        end
        chk("timeout_len", n, 5000);
        chk("timeout_cred", cred, 0);
        entrar(2, 6'b000010);
        avaliar("to_d2", 3'b111, 6'b000010, 1'b0, 2'd0);
        entrar(2, 6'b000001);
        avaliar("to_d3", 3'b111, 6'b000001, 1'b0, 2'd0);
        chk("timeout_fail_kept", locked, 1);
`else
        entrar(6, 6'b000001);
        avaliar("rl1", 3'b000, 6'b000001, 1'b0, 2'd0);
        entrar(1, 6'b000001);
        avaliar("rl2", 3'b111, 6'b000001, 1'b0, 2'd0);
        entrar(5, 6'b011111);
        avaliar("rl3", 3'b010, 6'b011111, 1'b0, 2'd0);
        chk("relock", locked, 1);
`endif
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_lock",
            {cred, cred_valid, granted, denied, level, locked, busy}, 0);
        rst = 1'b0;
        tick();
        entrar(6, 6'b111000);
        avaliar("after_rst", 3'b000, 6'b111000, 1'b0, 2'd0);
        chk("after_rst_nolock", locked, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/entrada_credencial_serial.md
# entrada_credencial_serial

Sequential credential front-end for the authentication comparator. Collects a 6-bit credential entered one bit at a time, presents it as A..F to the comparator for one check cycle, samples the AUT1..AUT3 response, and reports grant level or denial. Applies a lockout after repeated failures. Sits between the user input conditioning logic and the comparator.

## Interface
- `LOCK_TRIES`, 3: consecutive denials that trigger lockout (1..7).
- `LOCK_CYCLES`, 1000: lockout duration in clock cycles (≥1).
- `RESULT_CYCLES`, 50: cycles the result is held before returning to IDLE (≥1).
- `TIMEOUT_CYCLES`, 5000: entry inactivity limit (used only with the macro).
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `bit_in`, in, 1: credential bit value.
- `bit_valid`, in, 1: one-cycle pulse; accept `bit_in`.
- `confirm`, in, 1: one-cycle pulse; submit the credential.
- `clear`, in, 1: one-cycle pulse; discard the entry.
- `aut_in`, in, 3: comparator response {AUT3, AUT2, AUT1}; combinational from `cred`.
- `cred`, out, 6: {A,B,C,D,E,F}; A is the MSB.
- `cred_valid`, out, 1: high while `cred` is under check.
- `granted`, out, 1: access result.
- `denied`, out, 1: rejection result.
- `level`, out, 2: 3/2/1 = AUT3/AUT2/AUT1; 0 = none.
- `locked`, out, 1: lockout active.
- `busy`, out, 1: high in any state except IDLE.

## Operation
- States: IDLE, ENTRY, CHECK, RESULT, LOCKOUT.
- IDLE, on `bit_valid`: set `cred` = {5'b0, bit_in} and count = 1, then go to ENTRY. `confirm` and `clear` are ignored in IDLE.
- ENTRY, on `bit_valid` with count < 6: `cred` ← {cred[4:0], bit_in} and count is incremented. The first bit entered ends in A. Bits after the sixth are ignored.
- ENTRY, on `confirm`: go to CHECK. Entry data is kept.
- ENTRY, on `clear`: zero `cred` and count, then go to IDLE. The fail counter is unchanged.
- ENTRY priority when pulses coincide in one cycle: `clear` > `confirm` > `bit_valid`.
- CHECK lasts 1 cycle with `cred_valid` = 1. At the end of the cycle `aut_in` is sampled:
  - If count ≠ 6, the result is denied regardless of `aut_in`.
  - Otherwise the result is granted if any AUT bit is set. `level` takes the highest set bit.
- RESULT: `granted` or `denied` and `level` are held for `RESULT_CYCLES`, then the FSM goes to IDLE with `cred`, count and `level` cleared. All pulse inputs are ignored in CHECK and RESULT.
- Fail counter (3 bits):
  - Cleared on grant.
  - Incremented on denial.
  - When a denial brings it to `LOCK_TRIES`, the FSM goes from RESULT to LOCKOUT instead of IDLE.
- LOCKOUT: `locked` = 1 and all inputs are ignored for `LOCK_CYCLES`. Then the fail counter is cleared and the FSM goes to IDLE.

## Timing
- Reset:
  - FSM goes to IDLE.
  - `cred` = 0, count = 0, fail counter = 0.
  - `cred_valid`, `granted`, `denied`, `locked`, `busy` = 0; `level` = 0.
  - Reset takes effect from any state, including mid-entry and mid-lockout.
- `confirm` in cycle n → `cred_valid` = 1 in cycle n+1 → `granted`/`denied`/`level` valid from cycle n+2 through n+1+`RESULT_CYCLES`.
- Exactly one of `granted`/`denied` is high in RESULT; both are 0 elsewhere.
- All outputs are registered. `cred` is stable throughout CHECK.
- Lockout: `locked` rises in the cycle after the last RESULT cycle and stays high for exactly `LOCK_CYCLES` cycles.

## Configuration
- `ENTRADA_TIMEOUT_EN` defined: in ENTRY, `TIMEOUT_CYCLES` consecutive cycles without `bit_valid` or `confirm` act as `clear` (return to IDLE, no fail-count change).
- `ENTRADA_TIMEOUT_EN` undefined: ENTRY waits indefinitely, and no timeout counter is synthesized.

## Structure
- Package `entrada_credencial_pkg`:
  - State enum.
  - `CRED_W` = 6.
  - Level constants `NIVEL_NENHUM`/`NIVEL_1`/`NIVEL_2`/`NIVEL_3`.
- Sub-module `contador_intervalo`: loadable down-counter with a done flag. It is shared for the result hold, the lockout and the timeout (instantiated once; the three uses are mutually exclusive by state).

## Test plan
- Enter bits 0,1,1,0,0,0 and confirm; drive `aut_in` = 3'b001 while `cred_valid` = 1 → `cred` = 6'b011000, `granted` = 1, `level` = 1 for 50 cycles, then IDLE.
- Full entry with `aut_in` = 3'b110 → `level` = 3 and the fail counter is cleared.
- Confirm after 4 bits → `denied` = 1 even with `aut_in` = 3'b111.
- Three consecutive denials → `locked` = 1 for 1000 cycles, all inputs ignored, then IDLE and a successful grant works.
- Same-cycle `clear`+`confirm` in ENTRY → IDLE, no CHECK. Reset asserted mid-lockout → all outputs 0 in the next cycle.
- With `ENTRADA_TIMEOUT_EN`: 3 bits, then 5000 idle cycles → IDLE, `cred` = 0, fail count unchanged.
